// File: rtl/qam_pkg.sv
// Shared constants, symbol codes and FSM state type for the 16-QAM
// correlator receive path.
package qam_pkg;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned PERIOD      = 360;
    localparam int unsigned ACC_W       = 24;
    localparam int unsigned CARRIER_AMP = 100;
    localparam int unsigned PHASE_W     = 9;
    localparam int unsigned LUT_W       = 8;

    typedef logic [1:0] sym_code_t;

    // Gray order along one axis: -3, -1, +1, +3
    localparam sym_code_t GRAY_M3 = 2'b00;
    localparam sym_code_t GRAY_M1 = 2'b01;
    localparam sym_code_t GRAY_P1 = 2'b11;
    localparam sym_code_t GRAY_P3 = 2'b10;

    typedef enum logic {WAIT_SYNC, ACCUM} demod_state_t;
endpackage

// File: rtl/qam_correlator_demod_carrier_lut.sv
// Registered dual-read carrier table: sin at phase and cos at
// (phase+90) mod 360, built from a quarter-wave table of round(100*sin(k deg)).
module carrier_lut
    import qam_pkg::*;
(
    input  logic                    clk,
    input  logic [PHASE_W-1:0]      phase,
    output logic signed [LUT_W-1:0] sin_val,
    output logic signed [LUT_W-1:0] cos_val
);
    localparam logic [6:0] QUARTER [91] = '{
        0,  2,  3,  5,  7,  9, 10, 12, 14, 16,
        17, 19, 21, 22, 24, 26, 28, 29, 31, 33,
        34, 36, 37, 39, 41, 42, 44, 45, 47, 48,
        50, 52, 53, 54, 56, 57, 59, 60, 62, 63,
        64, 66, 67, 68, 69, 71, 72, 73, 74, 75,
        77, 78, 79, 80, 81, 82, 83, 84, 85, 86,
        87, 87, 88, 89, 90, 91, 91, 92, 93, 93,
        94, 95, 95, 96, 96, 97, 97, 97, 98, 98,
        98, 99, 99, 99, 99, 100, 100, 100, 100, 100,
        7'(CARRIER_AMP)
    };

    function automatic logic signed [LUT_W-1:0] sin_at(input logic [PHASE_W-1:0] k);
        logic [PHASE_W-1:0]      r;
        logic signed [LUT_W-1:0] mag;
        if (k <= PHASE_W'(90))       r = k;
        else if (k <= PHASE_W'(180)) r = PHASE_W'(180) - k;
        else if (k <= PHASE_W'(270)) r = k - PHASE_W'(180);
        else                         r = PHASE_W'(360) - k;
        mag = LUT_W'(QUARTER[r[6:0]]);
        return (k > PHASE_W'(180)) ? -mag : mag;
    endfunction

    logic [PHASE_W-1:0]      cos_phase;
    logic signed [LUT_W-1:0] sin_d, sin_q, cos_d, cos_q;

    always_comb begin
        cos_phase = phase + PHASE_W'(90);
        if (cos_phase >= PHASE_W'(360)) cos_phase = cos_phase - PHASE_W'(360);
        sin_d = sin_at(phase);
        cos_d = sin_at(cos_phase);
    end

    always_ff @(posedge clk) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
    end

    assign sin_val = sin_q;
    assign cos_val = cos_q;
endmodule

// File: rtl/qam_correlator_demod.sv
// Coherent 16-QAM demodulator: correlates one carrier period of samples
// against cos/sin references and slices each sum to a 2-bit Gray code.
module qam_correlator_demod
    import qam_pkg::*;
#(
    parameter int unsigned SAMPLE_W = qam_pkg::SAMPLE_W,
    parameter int unsigned PERIOD   = qam_pkg::PERIOD,
    parameter int unsigned ACC_W    = qam_pkg::ACC_W,
    parameter int          THR      = 1080000
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       sync,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic                       sym_valid,
    output logic [1:0]                 sym_i,
    output logic [1:0]                 sym_q,
    output logic signed [ACC_W-1:0]    acc_i,
    output logic signed [ACC_W-1:0]    acc_q
);
    localparam int unsigned        PROD_W     = SAMPLE_W + LUT_W;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PERIOD - 1);
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THR);
    localparam logic signed [ACC_W-1:0] THR_N = ACC_W'(-THR);

    demod_state_t               state_q, state_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic                       s0_valid_q, s0_valid_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
    logic [PHASE_W-1:0]         s0_phase_q, s0_phase_d;
    logic signed [SAMPLE_W-1:0] s0_sample_q, s0_sample_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        s0_valid_d  = 1'b0;
        s0_first_d  = 1'b0;
        s0_last_d   = 1'b0;
        s0_phase_d  = phase_q;
        s0_sample_d = sample_in;
        if (sample_valid && (sync || state_q == ACCUM)) begin
            s0_valid_d = 1'b1;
            state_d    = ACCUM;
            if (sync) begin
                // Sync restarts at phase 0; the first flag makes the MAC drop any partial sum.
                s0_phase_d = '0;
                s0_first_d = 1'b1;
                phase_d    = PHASE_W'(1);
            end else begin
                s0_first_d = (phase_q == '0);
                s0_last_d  = (phase_q == LAST_PHASE);
                phase_d    = s0_last_d ? '0 : phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            phase_q     <= '0;
            s0_valid_q  <= 1'b0;
            s0_first_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_phase_q  <= '0;
            s0_sample_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            s0_valid_q  <= s0_valid_d;
            s0_first_q  <= s0_first_d;
            s0_last_q   <= s0_last_d;
            s0_phase_q  <= s0_phase_d;
            s0_sample_q <= s0_sample_d;
        end
    end

    logic signed [LUT_W-1:0]    sin_ref, cos_ref;
    logic                       s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic signed [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;

    carrier_lut u_lut (
        .clk     (Clk),
        .phase   (s0_phase_q),
        .sin_val (sin_ref),
        .cos_val (cos_ref)
    );

    always_comb begin
        s1_valid_d  = s0_valid_q;
        s1_first_d  = s0_first_q;
        s1_last_d   = s0_last_q;
        s1_sample_d = s0_sample_q;
    end

    logic signed [PROD_W-1:0] prod_i, prod_q;
    logic signed [ACC_W-1:0]  sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic                     done_q, done_d;

    always_comb begin
        prod_i  = PROD_W'(s1_sample_q) * PROD_W'(cos_ref);
        prod_q  = PROD_W'(s1_sample_q) * PROD_W'(sin_ref);
        sum_i_d = sum_i_q;
        sum_q_d = sum_q_q;
        done_d  = s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
            sum_i_d = (s1_first_q ? '0 : sum_i_q) + ACC_W'(prod_i);
            sum_q_d = (s1_first_q ? '0 : sum_q_q) + ACC_W'(prod_q);
        end
    end

    function automatic sym_code_t slice(input logic signed [ACC_W-1:0] a);
        if (a < THR_N)       return GRAY_M3;
        else if (a < 0)      return GRAY_M1;
        else if (a < THR_P)  return GRAY_P1;
        else                 return GRAY_P3;
    endfunction

    logic                    sym_valid_q, sym_valid_d;
    sym_code_t               sym_i_q, sym_i_d, sym_q_q, sym_q_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;

    always_comb begin
        sym_valid_d = done_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        if (done_q) begin
            acc_i_d = sum_i_q;
            acc_q_d = sum_q_q;
            sym_i_d = slice(sum_i_q);
            sym_q_d = slice(sum_q_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sample_q <= '0;
            sum_i_q     <= '0;
            sum_q_q     <= '0;
            done_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_sample_q <= s1_sample_d;
            sum_i_q     <= sum_i_d;
            sum_q_q     <= sum_q_d;
            done_q      <= done_d;
            sym_valid_q <= sym_valid_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign acc_i     = acc_i_q;
    assign acc_q     = acc_q_q;
endmodule

// File: tb/tb_qam_correlator_demod.sv
// Bench for qam_correlator_demod: table of symbols scored against a real-valued
// carrier model, plus reset, re-sync and pipeline-flush sequences.
module tb_qam_correlator_demod;
    logic              Clk = 1'b0;
    logic              reset, sync, sample_valid;
    logic signed [7:0] sample_in;
    logic              sym_valid;
    logic [1:0]        sym_i, sym_q;
    logic signed [23:0] acc_i, acc_q;

    qam_correlator_demod #(
        .SAMPLE_W (8),
        .PERIOD   (360),
        .ACC_W    (24),
        .THR      (1080000)
    ) dut (
        .Clk          (Clk),
        .reset        (reset),
        .sync         (sync),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sym_valid    (sym_valid),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .acc_i        (acc_i),
        .acc_q        (acc_q)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         lvl_i;
        int         lvl_q;
        bit         gap;
        bit         sy;
        logic [1:0] exp_i;
        logic [1:0] exp_q;
    } vec_t;

    typedef struct {
        int         cyc;
        int         acc_i;
        int         acc_q;
        logic [1:0] code_i;
        logic [1:0] code_q;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t last_exp;
    int   sin_ref[360];
    int   cos_ref[360];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   pulse_cnt = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    function automatic int samp(input int k, input int li, input int lq);
        return rnd(0.3 * li * cos_ref[k] + 0.3 * lq * sin_ref[k]);
    endfunction

    // Every pulse must match the oldest expected symbol, on its exact cycle.
    always @(negedge Clk) begin
        if (sym_valid) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("acc_i", int'(acc_i), mon_e.acc_i);
                check("acc_q", int'(acc_q), mon_e.acc_q);
                check("sym_i", int'(sym_i), int'(mon_e.code_i));
                check("sym_q", int'(sym_q), int'(mon_e.code_q));
            end
        end
    end

    task automatic send_sample(input int s, input bit sy);
        sample_in    = 8'(s);
        sample_valid = 1'b1;
        sync         = sy;
        @(posedge Clk);
        #1;
        sample_valid = 1'b0;
        sync         = 1'b0;
    endtask

    task automatic idle(input bit noisy);
        sample_in    = 8'($urandom);
        sync         = noisy;
        sample_valid = 1'b0;
        @(posedge Clk);
        #1;
        sync = 1'b0;
    endtask

    task automatic drive_run(input int li, input int lq, input int n, input bit sy, input bit gap);
        for (int k = 0; k < n; k++) begin
            if (gap) idle(1'b1);
            send_sample(samp(k % 360, li, lq), sy && (k == 0));
        end
    endtask

    task automatic send_symbol(input vec_t v);
        exp_t e;
        e.acc_i = 0;
        e.acc_q = 0;
        for (int k = 0; k < 360; k++) begin
            e.acc_i += samp(k, v.lvl_i, v.lvl_q) * cos_ref[k];
            e.acc_q += samp(k, v.lvl_i, v.lvl_q) * sin_ref[k];
        end
        e.code_i = v.exp_i;
        e.code_q = v.exp_q;
        drive_run(v.lvl_i, v.lvl_q, 360, v.sy, v.gap);
        e.cyc = cyc + 3;
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge Clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sym_valid"}, int'(sym_valid), 0);
        check({tag, "_sym_i"}, int'(sym_i), 0);
        check({tag, "_sym_q"}, int'(sym_q), 0);
        check({tag, "_acc_i"}, int'(acc_i), 0);
        check({tag, "_acc_q"}, int'(acc_q), 0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t resync;
        int   p0;

        for (int k = 0; k < 360; k++) sin_ref[k] = rnd(100.0 * $sin(k * 3.14159265358979 / 180.0));
        for (int k = 0; k < 360; k++) cos_ref[k] = sin_ref[(k + 90) % 360];

        vecs[0] = '{ 0,  0, 1'b0, 1'b1, 2'b11, 2'b11};
        vecs[1] = '{ 3, -1, 1'b0, 1'b1, 2'b10, 2'b01};
        vecs[2] = '{ 3, -1, 1'b1, 1'b1, 2'b10, 2'b01};
        vecs[3] = '{-3,  1, 1'b0, 1'b1, 2'b00, 2'b11};
        vecs[4] = '{ 1,  3, 1'b0, 1'b0, 2'b11, 2'b10};
        vecs[5] = '{-1, -1, 1'b1, 1'b1, 2'b01, 2'b01};
        vecs[6] = '{ 1, -3, 1'b0, 1'b1, 2'b11, 2'b00};

        reset        = 1'b1;
        sync         = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;
        check_zero("reset");

        p0 = pulse_cnt;
        for (int n = 0; n < 1000; n++) send_sample(int'($urandom_range(255)) - 128, 1'b0);
        repeat (5) idle(1'b0);
        check("nosync_pulses", pulse_cnt - p0, 0);
        check("nosync_acc_i", int'(acc_i), 0);
        check("nosync_acc_q", int'(acc_q), 0);
        check("nosync_sym_i", int'(sym_i), 0);
        check("nosync_sym_q", int'(sym_q), 0);

        // Streamed with no idle between entries, so 3->4 is a back-to-back pair.
        foreach (vecs[i]) send_symbol(vecs[i]);
        repeat (6) idle(1'b0);
        check("hold_acc_i", int'(acc_i), last_exp.acc_i);
        check("hold_acc_q", int'(acc_q), last_exp.acc_q);

        drive_run(3, -1, 200, 1'b1, 1'b0);
        pulse_reset();
        check_zero("midreset");
        p0 = pulse_cnt;
        drive_run(3, -1, 360, 1'b0, 1'b0);
        repeat (6) idle(1'b0);
        check("midreset_no_pulse", pulse_cnt - p0, 0);
        send_symbol(vecs[1]);
        repeat (6) idle(1'b0);

        drive_run(-3, 1, 200, 1'b1, 1'b0);
        resync    = vecs[4];
        resync.sy = 1'b1;
        send_symbol(resync);
        repeat (6) idle(1'b0);

        p0 = pulse_cnt;
        drive_run(3, -1, 360, 1'b1, 1'b0);
        pulse_reset();
        repeat (6) idle(1'b0);
        check("flush_no_pulse", pulse_cnt - p0, 0);

        check("missing_pulses", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
